// File: rtl/axi4_mem_pkg.sv
// -----------------------------------------------------------------------------
// axi4_mem_pkg
// Shared types and helpers for the pipelined AXI4-side word memory.
//   MEM_DATA_W : reference word width the default response type is built on
//   STRB_W     : byte-strobe width for MEM_DATA_W
//   rsp_t      : one response record {we, err, rdata}
//   cfg_ok()   : legality check for read latency / response FIFO depth
// -----------------------------------------------------------------------------
package axi4_mem_pkg;

   localparam int MEM_DATA_W = 32;
   localparam int STRB_W     = MEM_DATA_W / 8;

   typedef struct packed {
      logic                  we;
      logic                  err;
      logic [MEM_DATA_W-1:0] rdata;
   } rsp_t;

   // Latency must be 1..4 and the FIFO must hold at least latency+1 entries,
   // otherwise the credit loop cannot sustain one request per clock.
   function automatic bit cfg_ok(input int read_latency, input int fifo_depth);
      return (read_latency >= 1) && (read_latency <= 4) &&
             (fifo_depth >= read_latency + 1);
   endfunction

endpackage

// File: rtl/axi4_mem_rsp_fifo.sv
// -----------------------------------------------------------------------------
// axi4_mem_rsp_fifo
// First-word-fall-through FIFO for response records. When empty, a push is
// visible on o_data in the same cycle, and a simultaneous pop consumes it
// without it ever being stored. Pointers wrap at DEPTH, so any depth >= 2 works.
//   i_clk    : clock
//   i_rst_n  : async active-low reset (pointers and count only)
//   i_push   : write i_data
//   i_data   : record to write
//   i_pop    : consume the head record
//   o_data   : head record (i_data when empty)
//   o_full   : DEPTH records stored
//   o_empty  : nothing stored
// -----------------------------------------------------------------------------
module axi4_mem_rsp_fifo
   import axi4_mem_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = rsp_t
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_push,
   input  T     i_data,
   input  logic i_pop,
   output T     o_data,
   output logic o_full,
   output logic o_empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   T                 r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_empty;
   logic w_store;
   logic w_drain;

   function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_empty = (r_count == '0);
   assign o_empty = w_empty;
   assign o_full  = (r_count == CNT_W'(DEPTH));

   // A push into an empty FIFO that is popped in the same cycle falls straight
   // through and is never written to storage.
   assign w_store = i_push & ~(w_empty & i_pop);
   assign w_drain = i_pop & ~w_empty;

   assign o_data  = w_empty ? i_data : r_mem[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (w_store) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_store) begin
            r_wr_ptr <= f_inc(r_wr_ptr);
         end
         if (w_drain) begin
            r_rd_ptr <= f_inc(r_rd_ptr);
         end
         case ({w_store, w_drain})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/axi4_mem_pipelined.sv
// -----------------------------------------------------------------------------
// axi4_mem_pipelined
// Single-port word memory with valid/ready request and response channels,
// byte write strobes, configurable read latency and out-of-range reporting.
// Every request (read or write) gets exactly one response, in request order.
//   ACLK       : clock
//   ARESETn    : async active-low reset
//   req_valid  : request present           req_ready : request can be accepted
//   req_we     : 1 = write, 0 = read       req_addr  : word address
//   req_wdata  : write data                req_wstrb : byte enables (writes)
//   rsp_valid  : response present          rsp_ready : consumer takes response
//   rsp_rdata  : read data (0 for writes/errors)
//   rsp_we     : echo of req_we            rsp_err   : address >= DEPTH
// -----------------------------------------------------------------------------
module axi4_mem_pipelined
   import axi4_mem_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int DEPTH          = 1024,
   parameter int READ_LATENCY   = 1,
   parameter int RSP_FIFO_DEPTH = 4
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_we,
   output logic                    rsp_err
);

   localparam int SW    = DATA_WIDTH / 8;
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

   if (!cfg_ok(READ_LATENCY, RSP_FIFO_DEPTH) || (DATA_WIDTH % 8) != 0 ||
       DEPTH < 2 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_cfg
      $error("axi4_mem_pipelined: illegal parameter combination");
   end

   // Same layout as rsp_t, sized to this instance's word width.
   typedef struct packed {
      logic                  we;
      logic                  err;
      logic [DATA_WIDTH-1:0] rdata;
   } rsp_w_t;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic                  r_pv  [READ_LATENCY];
   rsp_w_t                r_pd  [READ_LATENCY];
   logic [CNT_W-1:0]      r_outstanding;

   logic             w_acc;
   logic             w_in_range;
   logic [IDX_W-1:0] w_idx;
   logic             w_wr_en;
   logic             w_rd_en;
   logic             w_push;
   logic             w_pop;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   rsp_w_t           w_fifo_dout;

   // Ready depends only on the credit register, never on rsp_ready.
   assign req_ready  = ARESETn & (r_outstanding < CNT_W'(RSP_FIFO_DEPTH));
   assign w_acc      = req_valid & req_ready;
   assign w_in_range = ({1'b0, req_addr} < (ADDR_WIDTH + 1)'(DEPTH));
   assign w_idx      = req_addr[IDX_W-1:0];
   assign w_wr_en    = w_acc & req_we & w_in_range;
   assign w_rd_en    = w_acc & ~req_we & w_in_range;

   // Storage: no reset; only strobed bytes change.
   always_ff @(posedge ACLK) begin
      if (w_wr_en) begin
         for (int b = 0; b < SW; b++) begin
            if (req_wstrb[b]) begin
               r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
         end
      end
   end

   // Stage 0 captures the response at the accept edge. The read sees memory
   // as it was before this edge, which is correct since at most one request
   // is accepted per edge.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_pv[0] <= 1'b0;
         r_pd[0] <= '0;
      end else begin
         r_pv[0]       <= w_acc;
         r_pd[0].we    <= req_we;
         r_pd[0].err   <= ~w_in_range;
         r_pd[0].rdata <= w_rd_en ? r_mem[w_idx] : '0;
      end
   end

   for (genvar k = 1; k < READ_LATENCY; k++) begin : g_stage
      always_ff @(posedge ACLK or negedge ARESETn) begin
         if (!ARESETn) begin
            r_pv[k] <= 1'b0;
            r_pd[k] <= '0;
         end else begin
            r_pv[k] <= r_pv[k-1];
            r_pd[k] <= r_pd[k-1];
         end
      end
   end

   // The pipeline never stalls: credits guarantee a FIFO slot for every
   // entry in flight.
   assign w_push = r_pv[READ_LATENCY-1];
   assign w_pop  = rsp_valid & rsp_ready;

   axi4_mem_rsp_fifo #(
      .DEPTH (RSP_FIFO_DEPTH),
      .T     (rsp_w_t)
   ) u_rsp_fifo (
      .i_clk   (ACLK),
      .i_rst_n (ARESETn),
      .i_push  (w_push),
      .i_data  (r_pd[READ_LATENCY-1]),
      .i_pop   (w_pop),
      .o_data  (w_fifo_dout),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   assign rsp_valid = ~w_fifo_empty | w_push;
   assign rsp_rdata = rsp_valid ? w_fifo_dout.rdata : '0;
   assign rsp_we    = rsp_valid ? w_fifo_dout.we    : 1'b0;
   assign rsp_err   = rsp_valid ? w_fifo_dout.err   : 1'b0;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_outstanding <= '0;
      end else begin
         case ({w_acc, w_pop})
            2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
            2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESETn) begin
         a_no_overflow : assert (!(w_push && w_fifo_full && !w_pop));
      end
   end

endmodule

// File: tb/tb_axi4_mem_pipelined.sv
module tb_axi4_mem_pipelined;

   localparam int DW    = 32;
   localparam int AW    = 11;
   localparam int DEPTH = 1024;
   localparam int RL    = 2;
   localparam int FD    = 4;
   localparam int SW    = DW / 8;

   logic          ACLK = 1'b0;
   logic          ARESETn;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [SW-1:0] req_wstrb;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_we;
   logic          rsp_err;

   always #5 ACLK = ~ACLK;

   axi4_mem_pipelined #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .DEPTH          (DEPTH),
      .READ_LATENCY   (RL),
      .RSP_FIFO_DEPTH (FD)
   ) dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_we    (rsp_we),
      .rsp_err   (rsp_err)
   );

   typedef struct {
      logic          we;
      logic          err;
      logic [DW-1:0] rdata;
   } exp_t;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] wstrb;
      logic          exp_we;
      logic          exp_err;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   vec_t          vecs [$];
   exp_t          exp_q [$];
   int            hs_cyc_q [$];
   logic [DW-1:0] mdl_mem [DEPTH];

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_acc    = 0;
   int   n_hs     = 0;
   int   cyc      = 0;
   bit   stall_pending = 1'b0;
   exp_t stall_snap;
   exp_t mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(posedge ACLK) cyc++;

   // Reference model + scoreboard. Samples at the falling edge, so what it
   // sees is exactly what the next rising edge will act on.
   always @(negedge ACLK) begin
      if (!ARESETn) begin
         exp_q.delete();
         stall_pending = 1'b0;
      end else begin
         if (stall_pending) begin
            chk("hold_while_stalled",
                64'({rsp_valid, rsp_we, rsp_err, rsp_rdata}),
                64'({1'b1, stall_snap.we, stall_snap.err, stall_snap.rdata}));
         end
         stall_pending    = rsp_valid && !rsp_ready;
         stall_snap.we    = rsp_we;
         stall_snap.err   = rsp_err;
         stall_snap.rdata = rsp_rdata;

         if (rsp_valid && rsp_ready) begin
            n_hs++;
            hs_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_response: got we=%0b err=%0b rdata=0x%0h expected none",
                        rsp_we, rsp_err, rsp_rdata);
            end else begin
               mon_e = exp_q.pop_front();
               chk("scoreboard_rsp", 64'({rsp_we, rsp_err, rsp_rdata}),
                   64'({mon_e.we, mon_e.err, mon_e.rdata}));
            end
         end

         if (req_valid && req_ready) begin
            n_acc++;
            mon_e.we = req_we;
            if (int'(req_addr) >= DEPTH) begin
               mon_e.err   = 1'b1;
               mon_e.rdata = '0;
            end else begin
               mon_e.err = 1'b0;
               if (req_we) begin
                  for (int b = 0; b < SW; b++) begin
                     if (req_wstrb[b]) mdl_mem[req_addr[9:0]][8*b +: 8] = req_wdata[8*b +: 8];
                  end
                  mon_e.rdata = '0;
               end else begin
                  mon_e.rdata = mdl_mem[req_addr[9:0]];
               end
            end
            exp_q.push_back(mon_e);
         end
      end
   end

   // Called in the phase just after a rising edge; returns just after the
   // edge that accepted the request.
   task automatic issue(input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] s);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_wstrb = s;
      for (int i = 0; i < 50; i++) begin
         @(negedge ACLK);
         if (req_ready) begin
            @(posedge ACLK);
            #1;
            req_valid = 1'b0;
            return;
         end
         @(posedge ACLK);
         #1;
      end
      req_valid = 1'b0;
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: got req_ready=0 for 50 cycles expected 1 (addr 0x%0h)", a);
   endtask

   task automatic do_txn(input vec_t v, input string tag);
      int lat;
      bit got;
      issue(v.we, v.addr, v.wdata, v.wstrb);
      got = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge ACLK);
         if (rsp_valid) begin
            lat = i;
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_no_rsp: got no rsp_valid in 20 cycles expected one", tag);
      end else begin
         chk({tag, "_rsp"}, 64'({rsp_we, rsp_err, rsp_rdata}),
             64'({v.exp_we, v.exp_err, v.exp_rdata}));
         chk({tag, "_latency"}, 64'(lat), 64'(RL));
      end
      @(posedge ACLK);
      #1;
   endtask

   task automatic drain(input string tag);
      rsp_ready = 1'b1;
      req_valid = 1'b0;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
         @(posedge ACLK);
         #1;
      end
      chk({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
      chk({tag, "_idle"}, 64'(rsp_valid), 64'(0));
   endtask

   function automatic vec_t mk(input logic we, input int a, input logic [DW-1:0] d,
                               input logic [SW-1:0] s, input logic ewe, input logic eerr,
                               input logic [DW-1:0] erd);
      vec_t v;
      v.we = we; v.addr = AW'(a); v.wdata = d; v.wstrb = s;
      v.exp_we = ewe; v.exp_err = eerr; v.exp_rdata = erd;
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1);
   end

   initial begin
      int a0, c0, h0, sel;

      ARESETn   = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_wstrb = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;

      //          we  addr  wdata          strb   ewe eerr erdata
      vecs.push_back(mk(1, 5,    32'hDEADBEEF, 4'hF, 1, 0, 32'h0));
      vecs.push_back(mk(0, 5,    32'h0,        4'h0, 0, 0, 32'hDEADBEEF));
      vecs.push_back(mk(1, 5,    32'h11223344, 4'h5, 1, 0, 32'h0));
      vecs.push_back(mk(0, 5,    32'h0,        4'h0, 0, 0, 32'hDE22BE44));
      vecs.push_back(mk(1, 0,    32'hA5A50001, 4'hF, 1, 0, 32'h0));
      vecs.push_back(mk(0, 1024, 32'h0,        4'h0, 0, 1, 32'h0));
      vecs.push_back(mk(1, 1024, 32'hFFFFFFFF, 4'hF, 1, 1, 32'h0));
      vecs.push_back(mk(0, 0,    32'h0,        4'h0, 0, 0, 32'hA5A50001));
      vecs.push_back(mk(1, 1023, 32'h0BADF00D, 4'hF, 1, 0, 32'h0));
      vecs.push_back(mk(0, 1023, 32'h0,        4'h0, 0, 0, 32'h0BADF00D));
      vecs.push_back(mk(1, 7,    32'h12345678, 4'hF, 1, 0, 32'h0));
      vecs.push_back(mk(1, 7,    32'hFFFFFFFF, 4'h0, 1, 0, 32'h0));
      vecs.push_back(mk(1, 7,    32'hAABBCCDD, 4'h8, 1, 0, 32'h0));
      vecs.push_back(mk(0, 7,    32'h0,        4'h0, 0, 0, 32'hAA345678));
      vecs.push_back(mk(0, 2047, 32'h0,        4'h0, 0, 1, 32'h0));
      vecs.push_back(mk(1, 1100, 32'h55555555, 4'h3, 1, 1, 32'h0));

      #2;
      chk("reset_rsp_outputs", 64'({rsp_valid, rsp_we, rsp_err, rsp_rdata}), 64'(0));
      chk("reset_req_ready", 64'(req_ready), 64'(0));
      repeat (3) @(posedge ACLK);
      #3;
      ARESETn = 1'b1;
      @(posedge ACLK);
      #1;
      chk("ready_after_reset", 64'(req_ready), 64'(1));

      // Directed table
      for (int i = 0; i < vecs.size(); i++) begin
         do_txn(vecs[i], $sformatf("vec%0d", i));
      end
      drain("table");

      // Give every address used later a known value
      for (int a = 0; a < 16; a++) issue(1'b1, AW'(a), $urandom, 4'hF);
      for (int a = 1016; a < 1024; a++) issue(1'b1, AW'(a), $urandom, 4'hF);
      drain("prewrite");

      // 16 back-to-back reads, full throughput
      hs_cyc_q.delete();
      a0 = n_acc;
      c0 = cyc;
      for (int a = 0; a < 16; a++) issue(1'b0, AW'(a), '0, '0);
      chk("burst_accepts", 64'(n_acc - a0), 64'(16));
      chk("burst_cycles", 64'(cyc - c0), 64'(16));
      drain("burst");
      chk("burst_rsp_count", 64'(hs_cyc_q.size()), 64'(16));
      if (hs_cyc_q.size() == 16) begin
         chk("burst_rsp_spacing", 64'(hs_cyc_q[15] - hs_cyc_q[0]), 64'(15));
      end

      // Backpressure: credits stop acceptance at FD outstanding
      rsp_ready = 1'b0;
      a0 = n_acc;
      req_valid = 1'b1;
      req_we    = 1'b0;
      for (int i = 0; i < 10; i++) begin
         req_addr = AW'(i);
         @(posedge ACLK);
         #1;
      end
      req_valid = 1'b0;
      chk("stall_accepts", 64'(n_acc - a0), 64'(FD));
      chk("stall_req_ready", 64'(req_ready), 64'(0));
      chk("stall_queue", 64'(exp_q.size()), 64'(FD));
      repeat (3) @(posedge ACLK);
      #1;
      drain("stall");

      // Reset with reads in flight
      do_txn(mk(1, 9, 32'hCAFE0009, 4'hF, 1, 0, 32'h0), "pre_reset_wr");
      rsp_ready = 1'b0;
      issue(1'b0, AW'(1), '0, '0);
      issue(1'b0, AW'(2), '0, '0);
      issue(1'b0, AW'(3), '0, '0);
      repeat (2) @(posedge ACLK);
      #1;
      ARESETn = 1'b0;
      #1;
      chk("midreset_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("midreset_req_ready", 64'(req_ready), 64'(0));
      repeat (2) @(posedge ACLK);
      #3;
      ARESETn = 1'b1;
      rsp_ready = 1'b1;
      h0 = n_hs;
      repeat (6) @(posedge ACLK);
      #1;
      chk("postreset_no_stale", 64'(n_hs - h0), 64'(0));
      chk("postreset_req_ready", 64'(req_ready), 64'(1));
      do_txn(mk(0, 9, 32'h0, 4'h0, 0, 0, 32'hCAFE0009), "postreset_rd");

      // Randomised traffic against the model
      for (int i = 0; i < 500; i++) begin
         req_valid = ($urandom_range(0, 99) < 70);
         req_we    = 1'($urandom_range(0, 1));
         sel       = int'($urandom_range(0, 9));
         if (sel < 5)      req_addr = AW'($urandom_range(0, 15));
         else if (sel < 8) req_addr = AW'($urandom_range(1016, 1023));
         else              req_addr = AW'($urandom_range(1024, 2047));
         req_wdata = $urandom;
         req_wstrb = SW'($urandom_range(0, 15));
         rsp_ready = ($urandom_range(0, 99) < 65);
         @(posedge ACLK);
         #1;
      end
      drain("random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
